// File: rtl/alu_pkg.sv
// Shared definitions for the ALU time-sharing scheduler: opcode constants,
// the legal-opcode check and the scheduler state encoding.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    localparam logic [3:0] ALU_OP_ADD  = 4'h0;
    localparam logic [3:0] ALU_OP_SUB  = 4'h1;
    localparam logic [3:0] ALU_OP_SLL  = 4'h2;
    localparam logic [3:0] ALU_OP_SLT  = 4'h4;
    localparam logic [3:0] ALU_OP_SLTU = 4'h6;
    localparam logic [3:0] ALU_OP_XOR  = 4'h8;
    localparam logic [3:0] ALU_OP_SRL  = 4'hA;
    localparam logic [3:0] ALU_OP_SRA  = 4'hB;
    localparam logic [3:0] ALU_OP_OR   = 4'hC;
    localparam logic [3:0] ALU_OP_AND  = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
            ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_sched_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting index after
// the previous winner, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               valid_o
);

    logic [ID_W-1:0] cand;

    // Scanning from last_grant+1 gives the previous winner the lowest priority.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        cand        = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(last_grant_i) + off) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_share_sched.sv
// Time-shares one external combinational ALU32 among NUM_REQ requesters,
// returning each result tagged with the issuing requester index.
module alu_share_sched
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]  req_opcode,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [OP_W-1:0]          alu_opcode,
    input  logic [DATA_W-1:0]        alu_result,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [DATA_W-1:0]        resp_result,
    output logic                     resp_err,
    output logic [31:0]              ops_done
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     lastGrant_q;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   aluA_q, aluB_q, result_q;
    logic [OP_W-1:0]     aluOp_q;
    logic                err_q;
    logic [31:0]         opsDone_q;

    logic [DATA_W-1:0]   reqA  [NUM_REQ];
    logic [DATA_W-1:0]   reqB  [NUM_REQ];
    logic [OP_W-1:0]     reqOp [NUM_REQ];

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grantIdx;
    logic                anyValid;
    logic                grantEn;
    logic                issue;
    logic                respFire;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign reqA[g]  = req_a[DATA_W*g +: DATA_W];
        assign reqB[g]  = req_b[DATA_W*g +: DATA_W];
        assign reqOp[g] = req_opcode[OP_W*g +: OP_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (lastGrant_q),
        .grant_o      (grant),
        .grant_idx_o  (grantIdx),
        .valid_o      (anyValid)
    );

    // A grant may only be offered when the result slot is free or being drained this cycle.
    always_comb begin
        state_d = state_q;
        grantEn = 1'b0;
        case (state_q)
            IDLE: begin
                grantEn = 1'b1;
                if (anyValid) state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    grantEn = 1'b1;
                    state_d = anyValid ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue    = grantEn && anyValid;
    assign respFire = (state_q == RESP) && resp_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            lastGrant_q <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            aluA_q      <= '0;
            aluB_q      <= '0;
            aluOp_q     <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            opsDone_q   <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                aluA_q      <= reqA[grantIdx];
                aluB_q      <= reqB[grantIdx];
                aluOp_q     <= reqOp[grantIdx];
                id_q        <= grantIdx;
                lastGrant_q <= grantIdx;
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
                err_q    <= !is_legal_op(aluOp_q[3:0]);
            end
            if (respFire) opsDone_q <= opsDone_q + 32'd1;
        end
    end

    assign req_ready   = grantEn ? grant : '0;
    assign alu_a       = aluA_q;
    assign alu_b       = aluB_q;
    assign alu_opcode  = aluOp_q;
    assign resp_valid  = (state_q == RESP);
    assign resp_id     = id_q;
    assign resp_result = result_q;
    assign resp_err    = err_q;
    assign ops_done    = opsDone_q;

endmodule
